sensor_reader: RTL and testbench

Periodic sampling sequencer sitting directly upstream of the I2C `master`. It drives `master`'s `add`/`regis`/`send` inputs and consumes its `busy`/`dout` outputs. Every sample period it issues four single-byte reads of the heart-rate sensor FIFO data register. It then assembles IR and RED 16-bit samples and presents them on a valid/ready output.

---
 rtl/sensor_reader_pkg.sv | 22 ++
 rtl/sensor_reader_if.sv | 13 +
 rtl/sensor_reader_sample_tick_gen.sv | 36 +++
 rtl/sensor_reader.sv | 181 ++++++++++++++++++
 tb/tb_sensor_reader.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_reader_pkg.sv
// Shared types and constants for the heart-rate sensor sampling sequencer.
package sensor_reader_pkg;

  localparam logic [7:0]  REG_FIFO_DATA    = 8'h05;
  localparam int unsigned BYTES_PER_SAMPLE = 4;
  localparam int unsigned IDX_W            = $clog2(BYTES_PER_SAMPLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_REQ,
    S_WAIT_HI,
    S_WAIT_LO,
    S_NEXT,
    S_DONE
  } state_e;

  function automatic logic is_last_byte(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(BYTES_PER_SAMPLE - 1);
  endfunction

endpackage

// File: rtl/sensor_reader_if.sv
// Request/response bus between the sampling sequencer and the I2C master.
interface sensor_reader_if;

  logic [7:0] add;
  logic [7:0] regis;
  logic       send;
  logic       busy;
  logic [7:0] dout;

  modport master (output add, regis, send, input busy, dout);
  modport slave  (input add, regis, send, output busy, dout);

endinterface

// File: rtl/sensor_reader_sample_tick_gen.sv
// Sample-period counter: one-cycle tick on the wrap cycle while enabled.
module sample_tick_gen #(
  parameter int unsigned PERIOD_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned    CW   = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clearing while disabled makes the first tick land a full period after enable.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/sensor_reader.sv
// Periodic four-byte FIFO reader feeding an IR/RED valid/ready sample stream.
// Optional handshake watchdog: define SENSOR_READER_TIMEOUT_EN.
module sensor_reader
  import sensor_reader_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR       = 8'hAE,
  parameter int unsigned PERIOD_CYCLES  = 20000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_en,
  sensor_reader_if.master bus,
  output logic [15:0]     ir_data,
  output logic [15:0]     red_data,
  output logic            sample_valid,
  input  logic            sample_ready,
  output logic            overrun,
  output logic            err
);

  state_e                                state_q, state_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [BYTES_PER_SAMPLE-1:0][7:0]      buf_q, buf_d;
  logic                                  send_q, send_d;
  logic [7:0]                            add_q, add_d;
  logic [7:0]                            regis_q, regis_d;
  logic [15:0]                           ir_q, ir_d;
  logic [15:0]                           red_q, red_d;
  logic                                  valid_q, valid_d;
  logic                                  overrun_q, overrun_d;
  logic                                  tick;

  sample_tick_gen #(
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (start_en),
    .tick  (tick)
  );

`ifdef SENSOR_READER_TIMEOUT_EN
  localparam int unsigned     WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            timeout;

  assign timeout = (state_q == S_WAIT_HI || state_q == S_WAIT_LO) && (wd_q == WD_LIMIT);

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q | timeout;
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (wd_q != WD_LIMIT) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    send_d    = 1'b0;
    add_d     = DEV_ADDR;
    regis_d   = REG_FIFO_DATA;
    ir_d      = ir_q;
    red_d     = red_q;
    overrun_d = overrun_q;
    valid_d   = valid_q & ~sample_ready;

    unique case (state_q)
      S_IDLE: begin
        if (start_en) state_d = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (!start_en)  state_d = S_IDLE;
        else if (tick)  state_d = S_REQ;
      end
      S_REQ: begin
        if (!bus.busy) begin
          send_d  = 1'b1;
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (bus.busy) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!bus.busy) begin
          buf_d[idx_q] = bus.dout;
          state_d      = S_NEXT;
        end
      end
      // Output registers load on the edge into DONE so sample_valid rises one
      // cycle after the last byte capture; DONE itself only picks the exit.
      S_NEXT: begin
        if (is_last_byte(idx_q)) begin
          idx_d   = '0;
          state_d = S_DONE;
          if (valid_q && !sample_ready) begin
            overrun_d = 1'b1;
          end else begin
            ir_d    = {buf_q[0], buf_q[1]};
            red_d   = {buf_q[2], buf_q[3]};
            valid_d = 1'b1;
          end
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        state_d = start_en ? S_WAIT_TICK : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SENSOR_READER_TIMEOUT_EN
    if (timeout) begin
      idx_d   = '0;
      state_d = S_WAIT_TICK;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      buf_q     <= '0;
      send_q    <= 1'b0;
      add_q     <= '0;
      regis_q   <= '0;
      ir_q      <= '0;
      red_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      send_q    <= send_d;
      add_q     <= add_d;
      regis_q   <= regis_d;
      ir_q      <= ir_d;
      red_q     <= red_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.add      = add_q;
  assign bus.regis    = regis_q;
  assign bus.send     = send_q;
  assign ir_data      = ir_q;
  assign red_data     = red_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sensor_reader.sv
// Randomised bench for sensor_reader with a behavioural I2C master and sample model.
module tb_sensor_reader;

  localparam int unsigned PERIOD = 64;
  localparam int unsigned TMO    = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_en = 1'b0;
  logic        sample_ready = 1'b0;
  logic [15:0] ir_data, red_data;
  logic        sample_valid, overrun, err;

  sensor_reader_if bus ();

  sensor_reader #(
    .DEV_ADDR       (8'hAE),
    .PERIOD_CYCLES  (PERIOD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .start_en     (start_en),
    .bus          (bus.master),
    .ir_data      (ir_data),
    .red_data     (red_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .err          (err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          busy_len = 20;
  bit          hold_busy = 1'b0;
  bit          mute = 1'b0;
  logic [7:0]  fixed_q[$];
  logic [7:0]  acc[4];
  int          acc_n = 0;
  logic [31:0] exp_q[$];
  int          n_pulses = 0;
  int          send_w = 0;
  logic [7:0]  mb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural I2C master: answers each send with busy_len busy cycles and a byte.
  initial begin : i2c_master
    bus.busy = 1'b0;
    bus.dout = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.busy = 1'b0;
      end else if (hold_busy) begin
        bus.busy = 1'b1;
      end else if (bus.send && !mute) begin
        bus.busy = 1'b1;
        for (int c = 0; c < busy_len; c++) begin
          @(negedge clk);
          if (rst) break;
        end
        bus.busy = 1'b0;
        if (!rst) begin
          if (fixed_q.size() > 0) mb = fixed_q.pop_front();
          else                    mb = 8'($urandom);
          bus.dout   = mb;
          acc[acc_n] = mb;
          acc_n++;
          if (acc_n == 4) begin
            exp_q.push_back({acc[0], acc[1], acc[2], acc[3]});
            acc_n = 0;
          end
        end
      end else begin
        bus.busy = 1'b0;
      end
    end
  end

  initial begin : send_monitor
    forever begin
      @(negedge clk);
      if (bus.send === 1'b1) begin
        send_w++;
      end else begin
        if (send_w != 0) begin
          chk("send_width", send_w, 1);
          n_pulses++;
        end
        send_w = 0;
      end
    end
  end

  initial begin : global_guard
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic do_reset();
    rst          = 1'b1;
    start_en     = 1'b0;
    sample_ready = 1'b0;
    hold_busy    = 1'b0;
    mute         = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    fixed_q.delete();
    acc_n    = 0;
    n_pulses = 0;
    rst      = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_valid_wait"}, 0, 1);
  endtask

  task automatic accept_one(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_model_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, sample_valid, 1);
      chk({tag, "_ir"}, ir_data, e[31:16]);
      chk({tag, "_red"}, red_data, e[15:0]);
    end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    chk({tag, "_valid_drop"}, sample_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_add"}, bus.add, 0);
    chk({tag, "_regis"}, bus.regis, 0);
    chk({tag, "_send"}, bus.send, 0);
    chk({tag, "_valid"}, sample_valid, 0);
    chk({tag, "_ir"}, ir_data, 0);
    chk({tag, "_red"}, red_data, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  int          cyc;
  bit          seen;
  logic [31:0] e1;

  initial begin : stimulus
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst0");
    do_reset();
    chk("add_const", bus.add, 8'hAE);
    chk("regis_const", bus.regis, 8'h05);

    // Single sample with fixed bytes and a 20-cycle busy
    busy_len = 20;
    fixed_q  = '{8'h12, 8'h34, 8'h56, 8'h78};
    start_en = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.send) begin
        seen = 1'b1;
        break;
      end
    end
    chk("first_send_near_period", (seen && cyc >= PERIOD && cyc <= PERIOD + 2), 1);
    wait_valid("single", 400);
    chk("single_pulses", n_pulses, 4);
    chk("single_ir_const", ir_data, 16'h1234);
    chk("single_red_const", red_data, 16'h5678);
    chk("single_overrun", overrun, 0);
    accept_one("single");

    // Random bytes, busy lengths and consumer delays
    do_reset();
    start_en = 1'b1;
    for (int n = 0; n < 12; n++) begin
      busy_len = $urandom_range(1, 8);
      wait_valid("rnd", 400);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      accept_one("rnd");
    end
    chk("rnd_overrun", overrun, 0);
    chk("rnd_err", err, 0);

    // Backpressure across two samples
    do_reset();
    busy_len = 4;
    start_en = 1'b1;
    wait_valid("bp", 400);
    e1 = exp_q.pop_front();
    chk("bp_first_ir", ir_data, e1[31:16]);
    for (int i = 0; i < 400 && exp_q.size() == 0; i++) @(negedge clk);
    chk("bp_second_done", exp_q.size(), 1);
    start_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_held_ir", ir_data, e1[31:16]);
    chk("bp_held_red", red_data, e1[15:0]);
    chk("bp_held_valid", sample_valid, 1);
    chk("bp_overrun", overrun, 1);
    sample_ready = 1'b1;
    chk("bp_xfer_valid", sample_valid, 1);
    @(negedge clk);
    sample_ready = 1'b0;
    chk("bp_after_xfer_valid", sample_valid, 0);

    // Busy already high when the request is due
    do_reset();
    busy_len  = 3;
    hold_busy = 1'b1;
    start_en  = 1'b1;
    repeat (3 * PERIOD) @(negedge clk);
    chk("hold_no_send", n_pulses + send_w, 0);
    hold_busy = 1'b0;
    wait_valid("hold", 400);
    chk("hold_pulses", n_pulses, 4);
    accept_one("hold");

    // Reset while reading byte 2, with a sample pending at the output
    do_reset();
    busy_len = 10;
    start_en = 1'b1;
    wait_valid("mid", 400);
    for (int i = 0; i < 400 && !(acc_n == 2 && bus.busy); i++) @(negedge clk);
    chk("mid_reached_byte2", (acc_n == 2 && bus.busy), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    do_reset();
    busy_len = 5;
    start_en = 1'b1;
    wait_valid("mid_restart", 400);
    accept_one("mid_restart");

    // start_en drops during byte1
    do_reset();
    busy_len = 6;
    start_en = 1'b1;
    for (int i = 0; i < 400 && !(acc_n == 1 && bus.busy); i++) @(negedge clk);
    start_en = 1'b0;
    wait_valid("stop", 400);
    accept_one("stop");
    repeat (3 * PERIOD) @(negedge clk);
    chk("stop_pulses", n_pulses, 4);
    chk("stop_valid", sample_valid, 0);

    // Master never answers
    do_reset();
    mute     = 1'b1;
    start_en = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (bus.send) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tmo_send_seen", seen, 1);
    repeat (TMO - 5) @(negedge clk);
    chk("tmo_err_early", err, 0);
    repeat (10) @(negedge clk);
`ifdef SENSOR_READER_TIMEOUT_EN
    chk("tmo_err", err, 1);
`else
    chk("tmo_err", err, 0);
`endif
    chk("tmo_valid", sample_valid, 0);
    start_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
